// File: rtl/fpu_lib.sv
// Shared FPU types: operand format, condition codes, status flags, divider state and canonical NaN.
package fpu_lib;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

  typedef struct packed {
    logic z;
    logic c;
    logic n;
    logic v;
  } condCode_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic divByZero;
    logic invalid;
    logic inexact;
  } opStatusFlag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } divState_t;

  localparam fp16_t CANON_NAN16 = fp16_t'(16'h7E00);

endpackage

// File: rtl/fpu_div_sig_divider.sv
// Restoring significand divider: one quotient bit per cycle, QW bits, remainder-nonzero for sticky.
module fpu_sig_divider #(
  parameter int unsigned SIGW = 11,
  parameter int unsigned QW   = 13
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [SIGW-1:0] dividend,
  input  logic [SIGW-1:0] divisor,
  output logic            done,
  output logic [QW-1:0]   quotient,
  output logic            remNonZero
);

  localparam int unsigned RW = SIGW + 1;
  localparam int unsigned CW = $clog2(QW);

  logic [RW-1:0] rem;
  logic [RW-1:0] div;
  logic [RW-1:0] curRem;
  logic [RW-1:0] curDiv;
  logic [RW-1:0] diff;
  logic [CW-1:0] count;
  logic          busy;
  logic          ge;

  // The first quotient bit is resolved on the start edge straight from the inputs.
  always_comb begin
    curRem = busy ? rem : RW'(dividend);
    curDiv = busy ? div : RW'(divisor);
    ge     = curRem >= curDiv;
    diff   = ge ? curRem - curDiv : curRem;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      rem        <= '0;
      div        <= '0;
      count      <= '0;
      quotient   <= '0;
      remNonZero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy     <= 1'b1;
        div      <= curDiv;
        rem      <= {diff[RW-2:0], 1'b0};
        quotient <= QW'(ge);
        count    <= CW'(1);
      end else if (busy) begin
        rem      <= {diff[RW-2:0], 1'b0};
        quotient <= {quotient[QW-2:0], ge};
        count    <= count + CW'(1);
        if (count == CW'(QW - 1)) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          remNonZero <= diff != '0;
        end
      end
    end
  end

endmodule

// File: rtl/fpu_div.sv
// Floating-point divider: restoring significand iteration, RNE rounding, flush-to-zero, IEEE specials.
// Build macro FPU_DIV_EARLY_OUT_EN lets special operands skip the iteration and finish on the next edge.
module fpu_div
  import fpu_lib::*;
#(
  parameter type         FP_T  = fp16_t,
  parameter int unsigned FRACW = 10,
  parameter int unsigned EXPW  = 5,
  parameter int unsigned BIAS  = 15
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  FP_T           fpuIn1,
  input  FP_T           fpuIn2,
  output FP_T           fpuOut,
  output logic          done,
  output condCode_t     condCodes,
  output opStatusFlag_t opStatusFlags
);

  localparam int unsigned SIGW = FRACW + 1;
  localparam int unsigned QW   = FRACW + 3;
  localparam int unsigned XW   = EXPW + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXPW) - 1);
`ifdef FPU_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  divState_t state, stateNext;
  FP_T op1, op2, src1, src2, resNext;
  condCode_t     ccNext;
  opStatusFlag_t flagsNext;
  logic zero1, zero2, inf1, inf2, nan1, nan2, special, accept, sigStart;
  logic sigDone, sigRemNz, qMsb, guard, rnd, roundUp;
  logic [QW-1:0]          sigQuot;
  logic [SIGW-1:0]        mant;
  logic [SIGW:0]          mantRnd;
  logic signed [XW-1:0]   expRes;

  // In IDLE the live inputs feed the early-out path; afterwards the captured operands are used.
  always_comb begin
    src1     = (state == IDLE) ? fpuIn1 : op1;
    src2     = (state == IDLE) ? fpuIn2 : op2;
    zero1    = src1.exp == '0;
    zero2    = src2.exp == '0;
    inf1     = (&src1.exp) && (src1.frac == '0);
    inf2     = (&src2.exp) && (src2.frac == '0);
    nan1     = (&src1.exp) && (src1.frac != '0);
    nan2     = (&src2.exp) && (src2.frac != '0);
    special  = zero1 | zero2 | inf1 | inf2 | nan1 | nan2;
    accept   = (state == IDLE) && start;
    sigStart = accept && !(EARLY_OUT && special);
  end

  fpu_sig_divider #(.SIGW(SIGW), .QW(QW)) uSigDiv (
    .clock      (clock),
    .reset      (reset),
    .start      (sigStart),
    .dividend   ({1'b1, fpuIn1.frac}),
    .divisor    ({1'b1, fpuIn2.frac}),
    .done       (sigDone),
    .quotient   (sigQuot),
    .remNonZero (sigRemNz)
  );

  // Normalise a quotient in [0.5, 2) and round to nearest even.
  always_comb begin
    qMsb    = sigQuot[QW-1];
    mant    = qMsb ? sigQuot[QW-1:2] : sigQuot[QW-2:1];
    guard   = qMsb ? sigQuot[1] : sigQuot[0];
    rnd     = qMsb & sigQuot[0];
    roundUp = guard & (rnd | sigRemNz | mant[0]);
    mantRnd = {1'b0, mant} + (SIGW+1)'(roundUp);
    expRes  = XW'(src1.exp) + XW'(BIAS) - XW'(src2.exp) - XW'(!qMsb) + XW'(mantRnd[SIGW]);
  end

  always_comb begin
    resNext      = '0;
    flagsNext    = '0;
    resNext.sign = src1.sign ^ src2.sign;
    if (nan1 || nan2 || (zero1 && zero2) || (inf1 && inf2)) begin
      resNext.sign          = 1'b0;
      resNext.exp           = '1;
      resNext.frac[FRACW-1] = 1'b1;
      flagsNext.invalid     = (nan1 && !src1.frac[FRACW-1]) || (nan2 && !src2.frac[FRACW-1])
                              || !(nan1 || nan2);
    end else if (zero2 && !inf1) begin
      resNext.exp         = '1;
      flagsNext.divByZero = 1'b1;
    end else if (inf1) begin
      resNext.exp = '1;
    end else if (zero1 || inf2) begin
      resNext.exp = '0;
    end else begin
      flagsNext.inexact = guard | rnd | sigRemNz;
      if (expRes >= EXP_MAX) begin
        resNext.exp        = '1;
        flagsNext.overflow = 1'b1;
        flagsNext.inexact  = 1'b1;
      end else if (expRes <= $signed(XW'(0))) begin
        flagsNext.underflow = 1'b1;
        flagsNext.inexact   = 1'b1;
      end else begin
        resNext.exp  = EXPW'(expRes);
        resNext.frac = mantRnd[FRACW-1:0];
      end
    end
    ccNext   = '0;
    ccNext.z = (resNext.exp == '0) && (resNext.frac == '0);
    ccNext.n = resNext.sign;
    ccNext.v = flagsNext.overflow;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = (EARLY_OUT && special) ? DONE : DIVIDE;
      DIVIDE:  if (sigDone) stateNext = NORM;
      NORM:    stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Results are latched only when DONE is entered and held until the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      op1           <= '0;
      op2           <= '0;
      fpuOut        <= '0;
      done          <= 1'b0;
      condCodes     <= '0;
      opStatusFlags <= '0;
    end else begin
      done <= stateNext == DONE;
      if (accept) begin
        op1 <= fpuIn1;
        op2 <= fpuIn2;
      end
      if (stateNext == DONE && state != DONE) begin
        fpuOut        <= resNext;
        condCodes     <= ccNext;
        opStatusFlags <= flagsNext;
      end
    end
  end

endmodule

// File: tb/tb_fpu_div.sv
// Self-checking bench for fpu_div (fp16): directed vectors, randomized ops against an arithmetic model.
module tb_fpu_div;
  import fpu_lib::*;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  fp16_t         fpuIn1 = '0;
  fp16_t         fpuIn2 = '0;
  fp16_t         fpuOut;
  logic          done;
  condCode_t     condCodes;
  opStatusFlag_t opStatusFlags;

  int nChecks = 0;
  int nFails  = 0;

`ifdef FPU_DIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  fpu_div dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .fpuIn1        (fpuIn1),
    .fpuIn2        (fpuIn2),
    .fpuOut        (fpuOut),
    .done          (done),
    .condCodes     (condCodes),
    .opStatusFlags (opStatusFlags)
  );

  always #5 clock = ~clock;

  // Reference: exact integer quotient scaled by 2^24, then RNE on the remaining bits.
  function automatic void refDiv(input logic [15:0] a, input logic [15:0] b,
                                 output logic [15:0] r, output logic [4:0] fl, output int lat);
    int ea, eb, fa, fb, e, sh;
    logic s, aNan, bNan, aInf, bInf, aZ, bZ, inx, up;
    longint num, den, q, rm, mant, low, half;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    fa = int'(a[9:0]);   fb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    aNan = (ea == 31) && (fa != 0); bNan = (eb == 31) && (fb != 0);
    aInf = (ea == 31) && (fa == 0); bInf = (eb == 31) && (fb == 0);
    aZ = ea == 0; bZ = eb == 0;
    fl = '0;
    lat = (EARLY_OUT && (aNan || bNan || aInf || bInf || aZ || bZ)) ? 1 : 15;
    if (aNan || bNan || (aZ && bZ) || (aInf && bInf)) begin
      r = 16'h7E00;
      fl[1] = (aNan && fa < 512) || (bNan && fb < 512) || !(aNan || bNan);
    end else if (bZ && !aInf) begin
      r = {s, 15'h7C00}; fl[2] = 1'b1;
    end else if (aInf) begin
      r = {s, 15'h7C00};
    end else if (aZ || bInf) begin
      r = {s, 15'h0000};
    end else begin
      num = longint'(1024 + fa) << 24;
      den = longint'(1024 + fb);
      q = num / den; rm = num % den;
      e = ea - eb + 15;
      if (q >= (longint'(1) << 24)) sh = 14;
      else begin sh = 13; e = e - 1; end
      mant = q >> sh;
      low  = q & ((longint'(1) << sh) - 1);
      half = longint'(1) << (sh - 1);
      inx  = (low != 0) || (rm != 0);
      up   = (low > half) || (low == half && (rm != 0 || mant[0]));
      if (up) mant = mant + 1;
      if (mant == 2048) begin mant = 1024; e = e + 1; end
      if (e >= 31) begin
        r = {s, 15'h7C00}; fl = 5'b10001;
      end else if (e <= 0) begin
        r = {s, 15'h0000}; fl = 5'b01001;
      end else begin
        r = {s, 5'(e), 10'(mant - 1024)}; fl[0] = inx;
      end
    end
  endfunction

  // Issue one operation; lat counts edges with the accepting edge as 1 (-1 on timeout).
  task automatic runOp(input logic [15:0] a, input logic [15:0] b, input bit scramble,
                       output logic [15:0] res, output logic [4:0] fl, output logic [3:0] cc,
                       output int lat, output logic pulseEnd);
    @(negedge clock);
    fpuIn1 = fp16_t'(a); fpuIn2 = fp16_t'(b); start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; lat = 1;
    if (scramble) begin fpuIn1 = fp16_t'(16'($urandom)); fpuIn2 = fp16_t'(16'($urandom)); end
    while (!done && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) lat = -1;
    res = fpuOut; fl = opStatusFlags; cc = condCodes;
    @(posedge clock); #1;
    pulseEnd = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    nChecks++; if (fpuOut !== 16'h0) begin nFails++; $display("FAIL reset_out got %h want 0000", fpuOut); end
    nChecks++; if (done !== 1'b0) begin nFails++; $display("FAIL reset_done got %b want 0", done); end
    nChecks++; if (opStatusFlags !== 5'h0) begin nFails++; $display("FAIL reset_flags got %b want 00000", opStatusFlags); end
    nChecks++; if (condCodes !== 4'h0) begin nFails++; $display("FAIL reset_cc got %b want 0000", condCodes); end
    @(negedge clock); reset = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va [8] = '{16'h4600, 16'h3C00, 16'h3C00, 16'h0000, 16'h7BFF, 16'h8400, 16'h3C00, 16'h7C00};
    logic [15:0] vb [8] = '{16'h4200, 16'h4200, 16'h0000, 16'h0000, 16'h3800, 16'h7800, 16'h4000, 16'h3C00};
    logic [15:0] vr [8] = '{16'h4000, 16'h3555, 16'h7C00, 16'h7E00, 16'h7C00, 16'h8000, 16'h3800, 16'h7C00};
    logic [4:0]  vf [8] = '{5'b00000, 5'b00001, 5'b00100, 5'b00010, 5'b10001, 5'b01001, 5'b00000, 5'b00000};
    logic [3:0]  vc [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b1010, 4'b0000, 4'b0000};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] res; logic [4:0] fl; logic [3:0] cc; logic pe; int lat, expLat;
    for (int i = 0; i < 8; i++) begin
      runOp(va[i], vb[i], 1'b0, res, fl, cc, lat, pe);
      expLat = (EARLY_OUT && vs[i]) ? 1 : 15;
      nChecks++; if (res !== vr[i]) begin nFails++; $display("FAIL dir%0d_res %h/%h got %h want %h", i, va[i], vb[i], res, vr[i]); end
      nChecks++; if (fl !== vf[i]) begin nFails++; $display("FAIL dir%0d_flags got %b want %b", i, fl, vf[i]); end
      nChecks++; if (cc !== vc[i]) begin nFails++; $display("FAIL dir%0d_cc got %b want %b", i, cc, vc[i]); end
      nChecks++; if (lat !== expLat) begin nFails++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, expLat); end
      nChecks++; if (pe !== 1'b0) begin nFails++; $display("FAIL dir%0d_pulse done still high got %b want 0", i, pe); end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b, res, er; logic [4:0] fl, ef; logic [3:0] cc, ec; logic pe; int lat, el;
    for (int i = 0; i < 80; i++) begin
      case (i % 4)
        0:       begin a = 16'($urandom); b = 16'($urandom); end
        1:       begin a = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
                       b = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)}; end
        default: begin a = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)};
                       b = {1'($urandom), 5'($urandom_range(8, 22)), 10'($urandom)}; end
      endcase
      refDiv(a, b, er, ef, el);
      ec = {er[14:0] == 15'h0, 1'b0, er[15], ef[4]};
      runOp(a, b, 1'b1, res, fl, cc, lat, pe);
      nChecks++; if (res !== er) begin nFails++; $display("FAIL rnd%0d_res %h/%h got %h want %h", i, a, b, res, er); end
      nChecks++; if (fl !== ef) begin nFails++; $display("FAIL rnd%0d_flags %h/%h got %b want %b", i, a, b, fl, ef); end
      nChecks++; if (cc !== ec) begin nFails++; $display("FAIL rnd%0d_cc got %b want %b", i, cc, ec); end
      nChecks++; if (lat !== el) begin nFails++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, pulses;
    @(negedge clock);
    fpuIn1 = fp16_t'(16'h3C00); fpuIn2 = fp16_t'(16'h4000); start = 1'b1;
    @(posedge clock); #1;
    lat = 1; pulses = 0;
    // start stays asserted with junk operands for the whole operation
    while (!done && lat < 40) begin
      fpuIn1 = fp16_t'(16'($urandom)); fpuIn2 = fp16_t'(16'($urandom));
      @(posedge clock); #1;
      lat++;
    end
    start = 1'b0;
    nChecks++; if (lat !== 15) begin nFails++; $display("FAIL busy_latency got %0d want 15", lat); end
    nChecks++; if (fpuOut !== 16'h3800) begin nFails++; $display("FAIL busy_res got %h want 3800", fpuOut); end
    repeat (20) begin @(posedge clock); #1; if (done) pulses++; end
    nChecks++; if (pulses !== 0) begin nFails++; $display("FAIL busy_extra_done got %0d pulses want 0", pulses); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] res; logic [4:0] fl; logic [3:0] cc; logic pe; int lat, pulses;
    @(negedge clock);
    fpuIn1 = fp16_t'(16'h4600); fpuIn2 = fp16_t'(16'h4200); start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock); reset = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    nChecks++; if (fpuOut !== 16'h0) begin nFails++; $display("FAIL abort_out got %h want 0000", fpuOut); end
    nChecks++; if (opStatusFlags !== 5'h0 || condCodes !== 4'h0) begin nFails++;
      $display("FAIL abort_flags got %b/%b want 00000/0000", opStatusFlags, condCodes); end
    @(negedge clock); reset = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (25) begin @(posedge clock); #1; if (done) pulses++; end
    nChecks++; if (pulses !== 0) begin nFails++; $display("FAIL abort_done got %0d pulses want 0", pulses); end
    nChecks++; if (fpuOut !== 16'h0) begin nFails++; $display("FAIL abort_hold got %h want 0000", fpuOut); end
    runOp(16'h3C00, 16'h4000, 1'b0, res, fl, cc, lat, pe);
    nChecks++; if (res !== 16'h3800) begin nFails++; $display("FAIL after_abort_res got %h want 3800", res); end
    nChecks++; if (lat !== 15) begin nFails++; $display("FAIL after_abort_latency got %0d want 15", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
